// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-memory bus responder.
package mem_bus_pkg;

  // Access size as carried on size_i
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  // Responder FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } resp_state_t;

  // Largest supported wait-state count and the counter width it needs
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  // Clamp a requested wait-state count into the supported range
  function automatic int clamp_wait(input int req_wait);
    if (req_wait < 0) begin
      return 0;
    end
    if (req_wait > MAX_WAIT) begin
      return MAX_WAIT;
    end
    return req_wait;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling for the responder: store byte-lane steering and
// byte enables, load lane extraction with sign/zero extension, and the
// alignment / reserved-size check for the captured request.
module mem_lane_align
  import mem_bus_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mem_size_t                  i_size,
  input  logic                       i_unsigned,
  input  logic [$clog2(WIDTH/8)-1:0] i_lane,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic [WIDTH-1:0]           i_rword,
  output logic [WIDTH-1:0]           o_wlanes,
  output logic [WIDTH/8-1:0]         o_byte_en,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_align_err
);

  localparam int LANES = WIDTH / 8;
  localparam int LB    = $clog2(LANES);

  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;

  // Replicate right-aligned store data across every lane; byte enables pick the live ones
  always_comb begin
    o_wlanes = '0;
    case (i_size)
      SZ_BYTE: o_wlanes = {LANES{i_wdata[7:0]}};
      SZ_HALF: o_wlanes = {(LANES / 2){i_wdata[15:0]}};
      SZ_WORD: o_wlanes = i_wdata;
      default: o_wlanes = '0;
    endcase
  end

  // One enable per little-endian byte lane
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_byte_en
      assign o_byte_en[gi] = (i_size == SZ_WORD) ||
                             ((i_size == SZ_BYTE) && (int'(i_lane) == gi)) ||
                             ((i_size == SZ_HALF) && ((int'(i_lane) == gi) ||
                                                      (int'(i_lane) + 1 == gi)));
    end
  endgenerate

  // Halves are only ever extracted from an even lane; odd lanes are flagged as errors
  assign w_rbyte = i_rword[{i_lane, 3'b000} +: 8];
  assign w_rhalf = i_rword[{i_lane[LB-1:1], 4'b0000} +: 16];

  // Extend the addressed lane(s) to full width; word loads pass straight through
  always_comb begin
    o_rdata = '0;
    case (i_size)
      SZ_BYTE: o_rdata = i_unsigned ? {{(WIDTH - 8){1'b0}}, w_rbyte}
                                    : {{(WIDTH - 8){w_rbyte[7]}}, w_rbyte};
      SZ_HALF: o_rdata = i_unsigned ? {{(WIDTH - 16){1'b0}}, w_rhalf}
                                    : {{(WIDTH - 16){w_rhalf[15]}}, w_rhalf};
      SZ_WORD: o_rdata = i_rword;
      default: o_rdata = '0;
    endcase
  end

  // Misaligned half/word or the reserved size encoding
  always_comb begin
    o_align_err = 1'b0;
    case (i_size)
      SZ_HALF: o_align_err = i_lane[0];
      SZ_WORD: o_align_err = |i_lane;
      SZ_RSVD: o_align_err = 1'b1;
      default: o_align_err = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_bus_responder.sv
// Bus target for the core's data-memory port. Accepts one load/store at a time
// on req/ready, waits a fixed number of cycles, then commits the store (or
// reads the load) and pulses rvalid for one cycle with the sized result.
// The RESP state is the final cycle of a transaction; the edge that leaves it
// commits the store, registers rdata/err and raises rvalid for one cycle.
module data_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic             ready_o,
  output logic             rvalid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             err_o
);

  localparam int LANES    = WIDTH / 8;
  localparam int LB       = $clog2(LANES);
  localparam int WORDS    = 2 ** (DEPTH - LB);
  localparam int WAIT_EFF = clamp_wait(WAIT_STATES);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_EFF);

  // FSM and wait counter
  resp_state_t      r_state;
  resp_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_commit;

  // Request captured at accept; later input changes are ignored
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_we;
  mem_size_t        r_size;
  logic             r_unsigned;

  // Response registers
  logic             r_rvalid;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;

  // Byte-addressed storage organised as words; deliberately not reset
  logic [WIDTH-1:0] r_mem [WORDS];

  logic [WIDTH-1:0]       w_wlanes;
  logic [LANES-1:0]       w_byte_en;
  logic [WIDTH-1:0]       w_load_data;
  logic                   w_align_err;
  logic                   w_range_err;
  logic                   w_err;
  logic [DEPTH-LB-1:0]    w_word_idx;
  logic [WIDTH-1:0]       w_rword;

  assign ready_o  = (r_state == S_IDLE);
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  // Anything at or above 2**DEPTH has no backing storage
  assign w_range_err = |r_addr[WIDTH-1:DEPTH];
  assign w_err       = w_align_err | w_range_err;
  assign w_word_idx  = r_addr[DEPTH-1:LB];
  assign w_rword     = r_mem[w_word_idx];

  mem_lane_align #(
    .WIDTH (WIDTH)
  ) u_lane_align (
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_lane      (r_addr[LB-1:0]),
    .i_wdata     (r_wdata),
    .i_rword     (w_rword),
    .o_wlanes    (w_wlanes),
    .o_byte_en   (w_byte_en),
    .o_rdata     (w_load_data),
    .o_align_err (w_align_err)
  );

  // Next-state logic: accept in IDLE, count down in WAIT, finish in RESP
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_accept = 1'b1;
          if (WAIT_EFF == 0) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_commit     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counter and response registers; reset drops any in-flight request
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_rvalid <= w_commit;
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (r_we || w_err) ? '0 : w_load_data;
      end
    end
  end

  // Capture the request on the accepting edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= addr_i;
      r_wdata    <= wdata_i;
      r_we       <= we_i;
      r_size     <= mem_size_t'(size_i);
      r_unsigned <= unsigned_i;
    end
  end

  // Store commit: only enabled lanes of an error-free store are written
  always_ff @(posedge clk_i) begin
    if (w_commit && r_we && !w_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_byte_en[i]) begin
          r_mem[w_word_idx][i*8 +: 8] <= w_wlanes[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: a byte-level reference model predicts
// each response when the request is accepted; a monitor compares on rvalid.
module tb_data_bus_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  logic        req0, we0, uns0;
  logic [31:0] addr0, wdata0;
  logic [1:0]  size0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    string       tag;
  } sb_t;

  sb_t         sb[$];
  logic [7:0]  mdl[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_bus_responder #(.WIDTH(32), .DEPTH(16), .WAIT_STATES(WS)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .size_i(size), .unsigned_i(uns), .ready_o(ready),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  data_bus_responder #(.WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) u_dut_w0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .size_i(size0), .unsigned_i(uns0), .ready_o(ready0),
    .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte array, little-endian, sized and extended loads
  task automatic model_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic u,
                          output logic [31:0] rd, output logic e);
    int nb;
    logic [31:0] v;
    e  = (s == 2'd3) || (s == 2'd2 && a[1:0] != 2'b00) || (s == 2'd1 && a[0]) ||
         (a >= 32'h0001_0000);
    rd = '0;
    if (!e) begin
      nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      if (w) begin
        for (int i = 0; i < nb; i++) mdl[int'(a) + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++)
          v[8*i +: 8] = mdl.exists(int'(a) + i) ? mdl[int'(a) + i] : 8'h00;
        if (nb == 1)      rd = u ? v : {{24{v[7]}}, v[7:0]};
        else if (nb == 2) rd = u ? v : {{16{v[15]}}, v[15:0]};
        else              rd = v;
      end
    end
  endtask

  // Present one request, wait for accept, push the expected response.
  // lit=1 overrides the model prediction with a hand-derived value.
  task automatic issue(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s, input logic u,
                       input logic lit, input logic [31:0] ld, input logic le);
    sb_t e;
    logic [31:0] md;
    logic me;
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk({tag, "_ready_timeout"}, 32'(ready), 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d; size = s; uns = u;
    @(posedge clk);
    #1;
    model_op(w, a, d, s, u, md, me);
    e.data = lit ? ld : md;
    e.err  = lit ? le : me;
    e.acc  = cyc;
    e.tag  = tag;
    sb.push_back(e);
    req = 1'b0;
    addr = $urandom; wdata = $urandom; we = ~w; size = 2'($urandom_range(0, 3));
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Response monitor
  initial begin : mon
    sb_t e;
    forever begin
      @(negedge clk);
      if (rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'(rvalid), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("txn %s rdata=%h err=%0d lat=%0d", e.tag, rdata, err, cyc - e.acc);
          chk({e.tag, "_data"}, rdata, e.data);
          chk({e.tag, "_err"}, 32'(err), 32'(e.err));
          chk({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(WS + 1));
        end
      end
    end
  end

  initial begin : main
    int acc0, rv0;
    logic prev, consec;
    logic w;
    logic [1:0] s;
    logic [31:0] a;
    rst_n = 1'b0; req = 0; we = 0; addr = 0; wdata = 0; size = 0; uns = 0;
    req0 = 0; we0 = 1; addr0 = 32'h40; wdata0 = 32'h1234_5678; size0 = 2'd2; uns0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store, latency and ready timing
    issue("st_w10", 1, 32'h10, 32'hDEAD_BEEF, 2'd2, 0, 1, 32'h0, 0);
    chk("rdy_c0", 32'(ready), 32'd0);
    @(negedge clk); chk("rdy_c1", 32'(ready), 32'd0);
    @(negedge clk); chk("rdy_c2", 32'(ready), 32'd0);
    @(negedge clk); chk("rvalid_e3", 32'(rvalid), 32'd1);
    drain();
    issue("ld_w10", 0, 32'h10, 0, 2'd2, 0, 1, 32'hDEAD_BEEF, 0);

    // Byte store, signed/unsigned byte loads
    issue("st_b11", 1, 32'h11, 32'h0000_0080, 2'd0, 0, 1, 32'h0, 0);
    issue("ld_bs11", 0, 32'h11, 0, 2'd0, 0, 1, 32'hFFFF_FF80, 0);
    issue("ld_bu11", 0, 32'h11, 0, 2'd0, 1, 1, 32'h0000_0080, 0);
    issue("ld_w10b", 0, 32'h10, 0, 2'd2, 0, 1, 32'hDEAD_80EF, 0);

    // Half store/load and misaligned half
    issue("st_h12", 1, 32'h12, 32'h0000_A5A5, 2'd1, 0, 1, 32'h0, 0);
    issue("ld_hs12", 0, 32'h12, 0, 2'd1, 0, 1, 32'hFFFF_A5A5, 0);
    issue("ld_h13", 0, 32'h13, 0, 2'd1, 0, 1, 32'h0, 1);
    issue("st_h11", 1, 32'h11, 32'h0000_1234, 2'd1, 0, 1, 32'h0, 1);
    issue("st_rsvd", 1, 32'h10, 32'h5555_5555, 2'd3, 0, 1, 32'h0, 1);
    issue("ld_w10c", 0, 32'h10, 0, 2'd2, 0, 1, 32'hA5A5_80EF, 0);

    // Misaligned word and out-of-range stores leave storage alone
    issue("st_w0", 1, 32'h0, 32'h1122_3344, 2'd2, 0, 0, 0, 0);
    issue("st_w4", 1, 32'h4, 32'h5566_7788, 2'd2, 0, 0, 0, 0);
    issue("st_w2", 1, 32'h2, 32'hFFFF_FFFF, 2'd2, 0, 1, 32'h0, 1);
    issue("st_oor", 1, 32'h0001_0000, 32'hEEEE_EEEE, 2'd2, 0, 1, 32'h0, 1);
    issue("ld_w0", 0, 32'h0, 0, 2'd2, 0, 1, 32'h1122_3344, 0);
    issue("ld_w4", 0, 32'h4, 0, 2'd2, 0, 1, 32'h5566_7788, 0);
    issue("ld_oor", 0, 32'h0001_0010, 0, 2'd2, 0, 1, 32'h0, 1);
    issue("st_top", 1, 32'h0000_FFFC, 32'h0BAD_CAFE, 2'd2, 0, 0, 0, 0);
    issue("ld_top", 0, 32'h0000_FFFF, 0, 2'd0, 1, 1, 32'h0000_000B, 0);
    drain();

    // Continuous requests on the zero-wait instance
    acc0 = 0; rv0 = 0; prev = 0; consec = 0;
    req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ready0) acc0++;
      addr0 = 32'h40 + 32'($urandom_range(0, 3)) * 4;
      @(negedge clk);
      if (rvalid0) begin
        rv0++;
        if (prev) consec = 1'b1;
        chk("w0_err", 32'(err0), 32'd0);
      end
      prev = rvalid0;
    end
    req0 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid0) begin
        rv0++;
        if (prev) consec = 1'b1;
      end
      prev = rvalid0;
    end
    chk("w0_accepts", 32'(acc0), 32'd10);
    chk("w0_rvalids", 32'(rv0), 32'd10);
    chk("w0_no_b2b", 32'(consec), 32'd0);
    // Store then load back on the zero-wait instance
    we0 = 1'b1; addr0 = 32'h80; wdata0 = 32'h1234_5678; req0 = 1'b1;
    @(posedge clk); #1; req0 = 1'b0;
    @(negedge clk); @(negedge clk);
    we0 = 1'b0; req0 = 1'b1;
    @(posedge clk); #1; req0 = 1'b0; wdata0 = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("w0_ld_rvalid", 32'(rvalid0), 32'd1);
    chk("w0_ld_data", rdata0, 32'h1234_5678);

    // Reset while a store is in flight drops it
    issue("st_w20", 1, 32'h20, 32'hCAFE_F00D, 2'd2, 0, 0, 0, 0);
    issue("ld_w20", 0, 32'h20, 0, 2'd2, 0, 1, 32'hCAFE_F00D, 0);
    drain();
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0BAD_BEEF; size = 2'd2; uns = 0;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("ld_w20r", 0, 32'h20, 0, 2'd2, 0, 1, 32'hCAFE_F00D, 0);

    // Random mix in a pre-initialised window
    for (int i = 0; i < 16; i++) issue("init", 1, 32'h100 + 32'(i * 4), $urandom, 2'd2, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = 32'h100 + 32'($urandom_range(0, 63));
      issue("rnd", w, a, $urandom, s, 1'($urandom_range(0, 1)), 0, 0, 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
